alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one `alu2` instance between two requesters, r0 and r1. Candidates are an instruction-issue path and an address/compare path.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Two-stage pipeline: operand register, then result register. A single response bus carries a requester ID.
- Owns the architectural NZCV flags register, updated only by ops that request it.

Parameters:
- WIDTH, 32, operand/result width; must stay 32 to match `alu2`.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; 0 = in reset
- stall  input  1  1 blocks all new grants; in-flight ops still complete
- r0_valid  input  1  r0 request present
- r0_ready  output  1  r0 request accepted this cycle
- r0_srca  input  WIDTH  r0 operand A
- r0_srcb  input  WIDTH  r0 operand B
- r0_alucontrol  input  2  00 add, 01 sub, 10 and, 11 or
- r0_setflags  input  1  op updates flags register
- r1_valid, r1_ready, r1_srca, r1_srcb, r1_alucontrol, r1_setflags: same as r0, for r1
- resp_valid  output  1  response present, one-cycle pulse per op
- resp_id  output  1  0 = r0, 1 = r1
- resp_result  output  WIDTH  ALU result
- resp_flags  output  4  NZCV of this op, regardless of setflags
- flags  output  4  architectural NZCV register

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - stage-1 valid, resp_valid, resp_id, resp_result, resp_flags, flags (all 0);
  - last_grant is set to 1, so r0 wins first.
- Reset mid-operation: in-flight ops are discarded with no response; outputs hold reset values until reset=1.
- Arbitration is combinational from valid, stall and last_grant.
  - stall=1: r0_ready = r1_ready = 0.
  - stall=0, only one valid: that requester gets ready=1.
  - stall=0, both valid: the requester != last_grant gets ready=1; the other sees ready=0.
  - Neither valid: both ready=0.
  - ready never depends on the requester's own ready; requesters must not make valid depend on ready.
- Handshake: a transfer occurs at the rising edge when valid=1 and ready=1.
  - Requester must hold valid and its operands stable until transferred.
  - Dropping valid before transfer is permitted; the request is then lost and no response is produced.
- On transfer at edge E1:
  - stage-1 registers load srca, srcb, alucontrol, setflags and id; s1_valid=1;
  - last_grant <= granted id.
- With no transfer at an edge: s1_valid <= 0 and last_grant holds.
- Stage 1 drives `alu2` combinationally from the stage-1 registers.
- At the next edge E2, if s1_valid:
  - resp_valid <= 1; resp_id, resp_result and resp_flags <= stage-1 id and `alu2` aluresult/aluflags;
  - if setflags, flags <= aluflags.
- At E2, if not s1_valid: resp_valid <= 0; other resp_* hold; flags hold.
- Timing:
  - Latency: request handshake in cycle T gives resp_valid in cycle T+2.
  - Throughput: one op per cycle; back-to-back grants fill the pipeline.
- The response has no backpressure; consumers must take it in its valid cycle.
- Flag semantics are exactly those of `alu2` aluflags:
  - C is carry-out for add/sub and 0 for logic ops;
  - V is 0 for logic ops.
- Flags-register hazard: an op issued in cycle T sees the flags register updated at the end of T+1. There is no forwarding; the issuing logic handles it.
- stall asserted while an op is in stage 1: that op still completes.
- last_grant changes only on a transfer, so an idle or stalled cycle does not rotate priority.

Test Plan:
- Single op: r0 ADD 5+3, setflags=1 -> r0_ready=1 in T; in T+2 resp_valid=1, resp_id=0, resp_result=8, resp_flags=0000; flags=0000.
- Sub to zero: r1 SUB 5-5, setflags=1 -> in T+2 resp_result=0, resp_flags=0110 (Z,C); flags=0110.
- Overflow: r0 ADD 0x7FFFFFFF+1, setflags=0 -> resp_result=0x80000000, resp_flags=1001; flags unchanged.
- Contention after reset: both valid for 4 cycles, r0 AND 0xF0&0x3C, r1 OR 0xF0|0x0F -> grants alternate r0,r1,r0,r1; responses 0x30,0xFF,0x30,0xFF with resp_id 0,1,0,1 in consecutive cycles.
- Stall: both valid, stall=1 for 3 cycles -> both ready=0, no responses; an op accepted the cycle before stall still responds at T+2.
- Async reset: assert reset mid-flight with an op in stage 1 -> resp_valid=0 and flags=0 immediately, no response after release; first grant after release goes to r0 when both are valid.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu2: combinational 32-bit add/sub/and/or with NZCV flags; C and V are forced to 0 for logic ops.
// Zero latency, no handshake.
module alu2 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  alucontrol,
    output logic [31:0] aluresult,
    output logic [3:0]  aluflags
);
    logic [31:0] b_mux;
    logic [32:0] sum;
    logic        carry;
    logic        overflow;

    always_comb begin
        b_mux = alucontrol[0] ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_mux} + {32'b0, alucontrol[0]};
        case (alucontrol)
            2'b00, 2'b01: aluresult = sum[31:0];
            2'b10:        aluresult = a & b;
            default:      aluresult = a | b;
        endcase
        carry    = ~alucontrol[1] & sum[32];
        // Overflow when operands (after the sub inversion) share a sign that the sum does not.
        overflow = ~alucontrol[1] & ~(alucontrol[0] ^ a[31] ^ b[31]) & (a[31] ^ sum[31]);
        aluflags = {aluresult[31], (aluresult == 32'b0), carry, overflow};
    end
endmodule

// alu_arbiter: round-robin sharing of one alu2 between r0/r1, owns the NZCV register.
// Latency 2 cycles handshake->response; stall withholds ready, response has no backpressure.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_srca,
    input  logic [WIDTH-1:0] r0_srcb,
    input  logic [1:0]       r0_alucontrol,
    input  logic             r0_setflags,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_srca,
    input  logic [WIDTH-1:0] r1_srcb,
    input  logic [1:0]       r1_alucontrol,
    input  logic             r1_setflags,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic [3:0]       resp_flags,
    output logic [3:0]       flags
);
    logic             last_grant_q, last_grant_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_id_q, s1_id_d;
    logic [WIDTH-1:0] s1_srca_q, s1_srca_d;
    logic [WIDTH-1:0] s1_srcb_q, s1_srcb_d;
    logic [1:0]       s1_alucontrol_q, s1_alucontrol_d;
    logic             s1_setflags_q, s1_setflags_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic [3:0]       resp_flags_q, resp_flags_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;

    alu2 u_alu2 (
        .a          (s1_srca_q),
        .b          (s1_srcb_q),
        .alucontrol (s1_alucontrol_q),
        .aluresult  (alu_result),
        .aluflags   (alu_flags)
    );

    // On contention the side that did not win last time gets the grant.
    always_comb begin
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        if (!stall) begin
            if (r0_valid && r1_valid) begin
                r0_ready = last_grant_q;
                r1_ready = ~last_grant_q;
            end else begin
                r0_ready = r0_valid;
                r1_ready = r1_valid;
            end
        end
    end

    always_comb begin
        last_grant_d    = last_grant_q;
        s1_valid_d      = r0_ready | r1_ready;
        s1_id_d         = s1_id_q;
        s1_srca_d       = s1_srca_q;
        s1_srcb_d       = s1_srcb_q;
        s1_alucontrol_d = s1_alucontrol_q;
        s1_setflags_d   = s1_setflags_q;
        resp_valid_d    = s1_valid_q;
        resp_id_d       = resp_id_q;
        resp_result_d   = resp_result_q;
        resp_flags_d    = resp_flags_q;
        flags_d         = flags_q;

        if (r0_ready || r1_ready) begin
            last_grant_d    = r1_ready;
            s1_id_d         = r1_ready;
            s1_srca_d       = r1_ready ? r1_srca       : r0_srca;
            s1_srcb_d       = r1_ready ? r1_srcb       : r0_srcb;
            s1_alucontrol_d = r1_ready ? r1_alucontrol : r0_alucontrol;
            s1_setflags_d   = r1_ready ? r1_setflags   : r0_setflags;
        end

        if (s1_valid_q) begin
            resp_id_d     = s1_id_q;
            resp_result_d = alu_result;
            resp_flags_d  = alu_flags;
            if (s1_setflags_q) begin
                flags_d = alu_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q    <= 1'b1;
            s1_valid_q      <= 1'b0;
            s1_id_q         <= 1'b0;
            s1_srca_q       <= '0;
            s1_srcb_q       <= '0;
            s1_alucontrol_q <= 2'b00;
            s1_setflags_q   <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_id_q       <= 1'b0;
            resp_result_q   <= '0;
            resp_flags_q    <= 4'b0;
            flags_q         <= 4'b0;
        end else begin
            last_grant_q    <= last_grant_d;
            s1_valid_q      <= s1_valid_d;
            s1_id_q         <= s1_id_d;
            s1_srca_q       <= s1_srca_d;
            s1_srcb_q       <= s1_srcb_d;
            s1_alucontrol_q <= s1_alucontrol_d;
            s1_setflags_q   <= s1_setflags_d;
            resp_valid_q    <= resp_valid_d;
            resp_id_q       <= resp_id_d;
            resp_result_q   <= resp_result_d;
            resp_flags_q    <= resp_flags_d;
            flags_q         <= flags_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_flags  = resp_flags_q;
    assign flags       = flags_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed cases with literal expectations plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [31:0] r0_srca, r0_srcb, r1_srca, r1_srcb;
    logic [1:0]  r0_alucontrol, r1_alucontrol;
    logic        r0_setflags, r1_setflags;
    logic        resp_valid, resp_id;
    logic [31:0] resp_result;
    logic [3:0]  resp_flags, flags;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_srca(r0_srca), .r0_srcb(r0_srcb),
        .r0_alucontrol(r0_alucontrol), .r0_setflags(r0_setflags),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_srca(r1_srca), .r1_srcb(r1_srcb),
        .r1_alucontrol(r1_alucontrol), .r1_setflags(r1_setflags),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
        .resp_flags(resp_flags), .flags(flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          due;
        logic        id;
        logic [31:0] res;
        logic [3:0]  fl;
        logic        sf;
    } op_t;

    op_t         pq[$];
    int          cyc = 0;
    logic        m_last;
    logic        m_vld, m_id;
    logic [31:0] m_res;
    logic [3:0]  m_rfl, m_flags;
    logic        cap_r0, cap_r1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from plain signed/unsigned arithmetic.
    task automatic alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                           output logic [31:0] r, output logic [3:0] f);
        longint sa, sb, ua, ub, s;
        logic   cf, vf;
        sa = $signed(a); sb = $signed(b);
        ua = a;          ub = b;
        cf = 1'b0;       vf = 1'b0;
        case (c)
            2'd0: begin
                r  = a + b;
                cf = (ua + ub) > 64'sh0000_0000_FFFF_FFFF;
                s  = sa + sb;
                vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'd1: begin
                r  = a - b;
                cf = (ua >= ub);
                s  = sa - sb;
                vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'd2:    r = a & b;
            default: r = a | b;
        endcase
        f = {r[31], (r == 32'd0), cf, vf};
    endtask

    task automatic model_reset();
        pq.delete();
        m_last = 1'b1;
        m_vld = 1'b0; m_id = 1'b0; m_res = 32'd0; m_rfl = 4'd0; m_flags = 4'd0;
    endtask

    // Called at each falling edge: retire due ops, compare, then queue the transfer of the coming edge.
    task automatic model_step();
        logic e0, e1;
        op_t  o;
        m_vld = 1'b0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            o = pq.pop_front();
            m_vld = 1'b1; m_id = o.id; m_res = o.res; m_rfl = o.fl;
            if (o.sf) m_flags = o.fl;
        end
        e0 = 1'b0; e1 = 1'b0;
        if (!stall) begin
            if (r0_valid && r1_valid) begin
                if (m_last) e0 = 1'b1; else e1 = 1'b1;
            end else begin
                e0 = r0_valid; e1 = r1_valid;
            end
        end
        chk("r0_ready", r0_ready, e0);
        chk("r1_ready", r1_ready, e1);
        chk("resp_valid", resp_valid, m_vld);
        chk("resp_id", resp_id, m_id);
        chk("resp_result", resp_result, m_res);
        chk("resp_flags", resp_flags, m_rfl);
        chk("flags", flags, m_flags);
        cap_r0 = r0_ready;
        cap_r1 = r1_ready;
        if (reset && (e0 || e1)) begin
            o.due = cyc + 2;
            o.id  = e1;
            o.sf  = e1 ? r1_setflags : r0_setflags;
            if (e1) alu_ref(r1_srca, r1_srcb, r1_alucontrol, o.res, o.fl);
            else    alu_ref(r0_srca, r0_srcb, r0_alucontrol, o.res, o.fl);
            pq.push_back(o);
            m_last = e1;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
    endtask

    task automatic set_r0(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c, input logic sf);
        r0_valid = 1'b1; r0_srca = a; r0_srcb = b; r0_alucontrol = c; r0_setflags = sf;
    endtask

    task automatic set_r1(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c, input logic sf);
        r1_valid = 1'b1; r1_srca = a; r1_srcb = b; r1_alucontrol = c; r1_setflags = sf;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        idle();
        tick();
        tick();
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic gen_req(input logic v, input logic g, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] c, input logic sf,
                           output logic nv, output logic [31:0] na, output logic [31:0] nb,
                           output logic [1:0] nc, output logic nsf);
        nv = v; na = a; nb = b; nc = c; nsf = sf;
        if (v && !g) begin
            if ($urandom_range(0, 9) == 0) nv = 1'b0;
        end else begin
            nv  = ($urandom_range(0, 2) != 0);
            na  = rand_opnd();
            nb  = ($urandom_range(0, 5) == 0) ? na : rand_opnd();
            nc  = 2'($urandom_range(0, 3));
            nsf = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        set_r0(32'd0, 32'd0, 2'd0, 1'b0);
        set_r1(32'd0, 32'd0, 2'd0, 1'b0);
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_flags", flags, 4'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        reset = 1'b1;
        tick();

        // Single op: r0 5+3
        set_r0(32'd5, 32'd3, 2'd0, 1'b1);
        tick();
        chk("t1_ready", cap_r0, 1'b1);
        idle();
        tick();
        chk("t1_vld", resp_valid, 1'b1);
        chk("t1_id", resp_id, 1'b0);
        chk("t1_res", resp_result, 32'd8);
        chk("t1_rfl", resp_flags, 4'b0000);
        chk("t1_flags", flags, 4'b0000);

        // r1 5-5 -> Z,C
        set_r1(32'd5, 32'd5, 2'd1, 1'b1);
        tick();
        chk("t2_ready", cap_r1, 1'b1);
        idle();
        tick();
        chk("t2_id", resp_id, 1'b1);
        chk("t2_res", resp_result, 32'd0);
        chk("t2_rfl", resp_flags, 4'b0110);
        chk("t2_flags", flags, 4'b0110);

        // Signed overflow without setflags
        set_r0(32'h7FFF_FFFF, 32'd1, 2'd0, 1'b0);
        tick();
        idle();
        tick();
        chk("t3_res", resp_result, 32'h8000_0000);
        chk("t3_rfl", resp_flags, 4'b1001);
        chk("t3_flags", flags, 4'b0110);
        tick();

        // Contention straight after reset: r0 first, then alternating
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                set_r0(32'hF0, 32'h3C, 2'd2, 1'b0);
                set_r1(32'hF0, 32'h0F, 2'd3, 1'b0);
            end else begin
                idle();
            end
            tick();
            if (i < 4) begin
                chk("cont_r0_ready", cap_r0, (i % 2 == 0));
                chk("cont_r1_ready", cap_r1, (i % 2 == 1));
            end
            if (i >= 1) begin
                chk("cont_vld", resp_valid, 1'b1);
                chk("cont_id", resp_id, 32'((i - 1) % 2));
                chk("cont_res", resp_result, ((i - 1) % 2 == 0) ? 32'h30 : 32'hFF);
            end
        end
        idle();
        tick();

        // Stall: op accepted just before stall still completes
        set_r0(32'hFF, 32'h0F, 2'd2, 1'b0);
        tick();
        chk("stall_pre_ready", cap_r0, 1'b1);
        stall = 1'b1;
        set_r1(32'd9, 32'd9, 2'd0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("stall_r0_ready", cap_r0, 1'b0);
            chk("stall_r1_ready", cap_r1, 1'b0);
            chk("stall_vld", resp_valid, (j == 0));
        end
        chk("stall_res", resp_result, 32'h0F);
        idle();
        tick();
        tick();

        // Async reset with one op responding and one in stage 1
        set_r0(32'd0, 32'd1, 2'd1, 1'b1);
        tick();
        set_r0(32'd1, 32'd1, 2'd0, 1'b1);
        tick();
        idle();
        chk("ar_pre_vld", resp_valid, 1'b1);
        chk("ar_pre_flags", flags, 4'b1000);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("ar_vld", resp_valid, 1'b0);
        chk("ar_flags", flags, 4'd0);
        chk("ar_res", resp_result, 32'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ar_post_vld", resp_valid, 1'b0);
        end
        set_r0(32'd2, 32'd2, 2'd0, 1'b0);
        set_r1(32'd3, 32'd3, 2'd0, 1'b0);
        tick();
        chk("ar_first_r0", cap_r0, 1'b1);
        chk("ar_first_r1", cap_r1, 1'b0);
        idle();
        tick();
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            stall = ($urandom_range(0, 4) == 0);
            gen_req(r0_valid, cap_r0, r0_srca, r0_srcb, r0_alucontrol, r0_setflags,
                    r0_valid, r0_srca, r0_srcb, r0_alucontrol, r0_setflags);
            gen_req(r1_valid, cap_r1, r1_srca, r1_srcb, r1_alucontrol, r1_setflags,
                    r1_valid, r1_srca, r1_srcb, r1_alucontrol, r1_setflags);
            tick();
        end
        idle();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
